// File: rtl/cordic_seq_pkg.sv
// Shared types, constants and helpers for the CORDIC / DAC sample sequencer.
package cordic_seq_pkg;

    localparam int DEF_ANGLE_W = 13;
    localparam int DEF_DATA_W  = 12;

    // Binary angle measure: 2^ANGLE_W counts per full turn
    localparam int PI_BAM      = 4096;
    localparam int HALF_PI_BAM = 2048;
    localparam int DAC_OFFSET  = 2048;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CWAIT,
        S_DLOAD,
        S_DKICK
    } seq_state_e;

    // Two's complement negate; the most negative code maps to the most positive
    function automatic logic [DEF_DATA_W-1:0] sat_neg(input logic [DEF_DATA_W-1:0] x);
        logic [DEF_DATA_W-1:0] most_neg;
        most_neg = {1'b1, {(DEF_DATA_W-1){1'b0}}};
        if (x == most_neg) return ~most_neg;
        return -x;
    endfunction

    // Signed sample to offset binary for the DAC
    function automatic logic [DEF_DATA_W-1:0] to_offset(input logic [DEF_DATA_W-1:0] x);
        return x + DEF_DATA_W'(DAC_OFFSET);
    endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Folds a binary angle into [-pi/2, pi/2) for the CORDIC core; neg_o marks
// that the result must be negated (sin(p +/- pi) = -sin(p), same for cos).
module cordic_quadrant_fold
    import cordic_seq_pkg::*;
#(
    parameter int ANGLE_W = DEF_ANGLE_W
)(
    input  logic [ANGLE_W-1:0] phase_i,
    output logic [ANGLE_W-1:0] angle_o,
    output logic               neg_o
);

    localparam logic signed [ANGLE_W-1:0] HALF_PI     = ANGLE_W'(HALF_PI_BAM);
    localparam logic signed [ANGLE_W-1:0] NEG_HALF_PI = -HALF_PI;
    localparam logic        [ANGLE_W-1:0] PI          = ANGLE_W'(PI_BAM);

    logic signed [ANGLE_W-1:0] p;
    assign p = $signed(phase_i);

    // Shift by half a turn when outside the core's convergence range
    always_comb begin
        angle_o = phase_i;
        neg_o   = 1'b0;
        if (p >= HALF_PI) begin
            angle_o = phase_i - PI;
            neg_o   = 1'b1;
        end else if (p < NEG_HALF_PI) begin
            angle_o = phase_i + PI;
            neg_o   = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_dac_sequencer.sv
// Sample-rate sequencer: paces phase advance, launches the CORDIC core and
// hands offset-binary sin/cos to the DAC serializer.
// Optional: define SEQ_OVERRUN_CNT_EN to add the dropped-tick counter port.
module cordic_dac_sequencer
    import cordic_seq_pkg::*;
#(
    parameter int ANGLE_W        = DEF_ANGLE_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SAMPLE_DIV     = 2000,
    parameter int CORDIC_TIMEOUT = 64
)(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [ANGLE_W-1:0] step_i,
    output logic               cordic_start_o,
    output logic [ANGLE_W-1:0] cordic_angle_o,
    input  logic               cordic_done_i,
    input  logic [DATA_W-1:0]  cordic_sin_i,
    input  logic [DATA_W-1:0]  cordic_cos_i,
    input  logic               dac_busy_i,
    output logic               dac_start_o,
    output logic [DATA_W-1:0]  dac_ch1_o,
    output logic [DATA_W-1:0]  dac_ch2_o,
    output logic [ANGLE_W-1:0] phase_o,
    output logic               busy_o,
    output logic               timeout_err_o
`ifdef SEQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]         overrun_cnt_o
`endif
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int TW = $clog2(CORDIC_TIMEOUT) + 1;

    seq_state_e         state_q, state_d;
    logic [PW-1:0]      pace_q, pace_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               start_q, start_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               neg_q, neg_d;
    logic [DATA_W-1:0]  ch1_q, ch1_d, ch2_q, ch2_d;
    logic [ANGLE_W-1:0] phase_q, phase_d;
    logic               err_q, err_d;

    logic               tick;
    logic [ANGLE_W-1:0] fold_angle;
    logic               fold_neg;

    cordic_quadrant_fold #(.ANGLE_W(ANGLE_W)) u_fold (
        .phase_i (phase_q),
        .angle_o (fold_angle),
        .neg_o   (fold_neg)
    );

    assign tick = enable_i && (pace_q == PW'(SAMPLE_DIV - 1));

    // Pace counter: free-runs while enabled, parked at zero otherwise
    always_comb begin
        pace_d = pace_q + PW'(1);
        if (!enable_i || tick) pace_d = '0;
    end

    // Next-state and datapath updates for the sample sequence
    always_comb begin
        state_d = state_q;
        tcnt_d  = '0;
        start_d = 1'b0;
        angle_d = angle_q;
        neg_d   = neg_q;
        ch1_d   = ch1_q;
        ch2_d   = ch2_q;
        phase_d = phase_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    angle_d = fold_angle;
                    neg_d   = fold_neg;
                    start_d = 1'b1;
                    state_d = S_CWAIT;
                end
            end
            S_CWAIT: begin
                tcnt_d = tcnt_q + TW'(1);
                if (cordic_done_i) begin
                    ch1_d   = to_offset(neg_q ? sat_neg(cordic_sin_i) : cordic_sin_i);
                    ch2_d   = to_offset(neg_q ? sat_neg(cordic_cos_i) : cordic_cos_i);
                    state_d = S_DLOAD;
                end else if (tcnt_q == TW'(CORDIC_TIMEOUT - 1)) begin
                    // Core never answered: flag it and drop this sample
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DLOAD: begin
                if (!dac_busy_i) state_d = S_DKICK;
            end
            S_DKICK: begin
                phase_d = phase_q + step_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pace_q  <= '0;
            tcnt_q  <= '0;
            start_q <= 1'b0;
            angle_q <= '0;
            neg_q   <= 1'b0;
            ch1_q   <= '0;
            ch2_q   <= '0;
            phase_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pace_q  <= pace_d;
            tcnt_q  <= tcnt_d;
            start_q <= start_d;
            angle_q <= angle_d;
            neg_q   <= neg_d;
            ch1_q   <= ch1_d;
            ch2_q   <= ch2_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

`ifdef SEQ_OVERRUN_CNT_EN
    logic [7:0] ovr_q, ovr_d;

    // Saturating count of ticks dropped while a sample was in flight
    always_comb begin
        ovr_d = ovr_q;
        if (tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    end

    // Overrun counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) ovr_q <= '0;
        else       ovr_q <= ovr_d;
    end

    assign overrun_cnt_o = ovr_q;
`endif

    assign cordic_start_o = start_q;
    assign cordic_angle_o = angle_q;
    assign dac_start_o    = (state_q == S_DKICK);
    assign dac_ch1_o      = ch1_q;
    assign dac_ch2_o      = ch2_q;
    assign phase_o        = phase_q;
    assign busy_o         = (state_q != S_IDLE);
    assign timeout_err_o  = err_q;

endmodule

// File: tb/tb_cordic_dac_sequencer.sv
// Self-checking bench for cordic_dac_sequencer with a CORDIC core stand-in.
module tb_cordic_dac_sequencer;

    localparam int ANGLE_W        = 13;
    localparam int DATA_W         = 12;
    localparam int SAMPLE_DIV     = 16;
    localparam int CORDIC_TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic [ANGLE_W-1:0] step = '0;
    logic               cordic_start;
    logic [ANGLE_W-1:0] cordic_angle;
    logic               cordic_done = 1'b0;
    logic [DATA_W-1:0]  cordic_sin = '0;
    logic [DATA_W-1:0]  cordic_cos = '0;
    logic               dac_busy = 1'b0;
    logic               dac_start;
    logic [DATA_W-1:0]  dac_ch1, dac_ch2;
    logic [ANGLE_W-1:0] phase;
    logic               busy, timeout_err;
`ifdef SEQ_OVERRUN_CNT_EN
    logic [7:0]         overrun_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mphase = 0;
    int mstep = 0;
    int start_cyc = 0;
    int kick_cyc = 0;
    int last_wait = 0;

    cordic_dac_sequencer #(
        .ANGLE_W(ANGLE_W), .DATA_W(DATA_W),
        .SAMPLE_DIV(SAMPLE_DIV), .CORDIC_TIMEOUT(CORDIC_TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .step_i(step),
        .cordic_start_o(cordic_start), .cordic_angle_o(cordic_angle),
        .cordic_done_i(cordic_done), .cordic_sin_i(cordic_sin), .cordic_cos_i(cordic_cos),
        .dac_busy_i(dac_busy), .dac_start_o(dac_start),
        .dac_ch1_o(dac_ch1), .dac_ch2_o(dac_ch2),
        .phase_o(phase), .busy_o(busy), .timeout_err_o(timeout_err)
`ifdef SEQ_OVERRUN_CNT_EN
        ,
        .overrun_cnt_o(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rules written directly from the angle arithmetic
    function automatic int wrap(input int p);
        int r;
        r = p % 8192;
        if (r < 0) r += 8192;
        if (r >= 4096) r -= 8192;
        return r;
    endfunction

    function automatic int fold_angle(input int p);
        if (p >= 2048) return p - 4096;
        if (p < -2048) return p + 4096;
        return p;
    endfunction

    function automatic bit fold_neg(input int p);
        return (p >= 2048) || (p < -2048);
    endfunction

    function automatic int dac_word(input int v, input bit neg);
        int x;
        x = neg ? -v : v;
        if (x > 2047) x = 2047;
        return x + 2048;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_step(input int v);
        mstep = wrap(v);
        step  = ANGLE_W'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mphase = 0;
    endtask

    task automatic wait_start(output int waited);
        waited = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cordic_start) begin
                waited = i;
                break;
            end
        end
        chk("start_seen", int'(cordic_start), 1);
    endtask

    // One full sample: core answers after lat cycles, DAC busy for hold cycles
    task automatic do_sample(input int s, input int c, input int lat, input int hold);
        int   ang, w;
        bit   ng;
        logic any_ds;
        ang = fold_angle(mphase);
        ng  = fold_neg(mphase);
        wait_start(w);
        last_wait = w;
        start_cyc = cyc;
        chk("cordic_angle", int'($signed(cordic_angle)), ang);
        @(negedge clk);
        chk("start_one_cycle", int'(cordic_start), 0);
        repeat (lat - 2) @(negedge clk);
        if (hold > 0) dac_busy = 1'b1;
        cordic_done = 1'b1;
        cordic_sin  = DATA_W'(s);
        cordic_cos  = DATA_W'(c);
        @(negedge clk);
        cordic_done = 1'b0;
        cordic_sin  = '0;
        cordic_cos  = '0;
        chk("dac_ch1", int'(dac_ch1), dac_word(s, ng));
        chk("dac_ch2", int'(dac_ch2), dac_word(c, ng));
        chk("dac_start_early", int'(dac_start), 0);
        any_ds = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            any_ds |= dac_start;
        end
        dac_busy = 1'b0;
        if (hold > 0) chk("dac_start_while_busy", int'(any_ds), 0);
        @(negedge clk);
        kick_cyc = cyc;
        chk("dac_start", int'(dac_start), 1);
        mphase = wrap(mphase + mstep);
        @(negedge clk);
        chk("dac_start_pulse", int'(dac_start), 0);
        chk("phase", int'($signed(phase)), mphase);
        chk("idle_after", int'(busy), 0);
    endtask

    initial begin
        int   w, n, s, c;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cordic_start", int'(cordic_start), 0);
        chk("rst_cordic_angle", int'(cordic_angle), 0);
        chk("rst_dac_ch1", int'(dac_ch1), 0);
        chk("rst_dac_ch2", int'(dac_ch2), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_dac_start", int'(dac_start), 0);
`ifdef SEQ_OVERRUN_CNT_EN
        chk("rst_overrun_cnt", int'(overrun_cnt), 0);
`endif
        rst = 1'b0;

        // Disabled: no launches
        set_step(50);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= cordic_start;
        end
        chk("no_start_disabled", int'(seen), 0);

        // Basic run: angles 0, 50, 100
        enable = 1'b1;
        do_sample(0, 2047, 10, 0);
        chk("first_tick_latency", last_wait, SAMPLE_DIV);
        chk("ch1_zero_sin", int'(dac_ch1), 2048);
        chk("ch2_full_cos", int'(dac_ch2), 4095);
        do_sample(0, 2047, 10, 0);
        do_sample(0, 2047, 10, 0);
        chk("phase_150", int'($signed(phase)), 150);

        // Phase 3000 folds to -1096 with negation
        do_reset();
        set_step(3000);
        do_sample(0, 2047, 10, 0);
        set_step(0);
        do_sample(500, -1200, 10, 0);
        chk("angle_fold_3000", int'($signed(cordic_angle)), -1096);
        chk("ch1_neg_500", int'(dac_ch1), 1548);
        chk("ch2_neg_m1200", int'(dac_ch2), 3248);
        do_sample(-2048, 0, 6, 0);
        chk("ch1_sat_neg", int'(dac_ch1), 4095);

        // Wrap through zero and negative steps
        do_reset();
        set_step(-6);
        do_sample(1, 2, 4, 0);
        set_step(50);
        do_sample(3, 4, 4, 0);
        chk("phase_wrap_44", int'($signed(phase)), 44);

        // Random steps, results and core latency
        for (int k = 0; k < 16; k++) begin
            set_step(int'($urandom_range(0, 8191)) - 4096);
            s = int'($urandom_range(0, 4095)) - 2048;
            c = int'($urandom_range(0, 4095)) - 2048;
            do_sample(s, c, int'($urandom_range(2, 12)), 0);
        end

        // Core never answers: timeout after CORDIC_TIMEOUT cycles in CWAIT
        wait_start(w);
        n = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                n = i;
                break;
            end
        end
        chk("timeout_cycles", n, CORDIC_TIMEOUT);
        chk("timeout_idle", int'(busy), 0);
        chk("timeout_phase_kept", int'($signed(phase)), mphase);
        do_sample(-700, 900, 8, 0);
        chk("timeout_sticky", int'(timeout_err), 1);

        // DAC busy for 100 cycles: ticks dropped, phase advances once
        do_reset();
        chk("err_cleared_by_rst", int'(timeout_err), 0);
        set_step(50);
        do_sample(100, 200, 10, 100);
`ifdef SEQ_OVERRUN_CNT_EN
        chk("overrun_cnt", int'(overrun_cnt), (kick_cyc - (start_cyc - 1)) / SAMPLE_DIV);
`endif
        do_sample(0, 0, 10, 0);
        chk("phase_once_then_next", int'($signed(phase)), 100);

        // Reset while waiting on the core aborts the sample
        wait_start(w);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_start", int'(cordic_start), 0);
        chk("abort_angle", int'(cordic_angle), 0);
        chk("abort_phase", int'(phase), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ch1", int'(dac_ch1), 0);
        rst = 1'b0;
        @(negedge clk);
        cordic_done = 1'b1;
        cordic_sin  = DATA_W'(1000);
        cordic_cos  = DATA_W'(-1000);
        @(negedge clk);
        cordic_done = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= dac_start;
        end
        chk("late_done_no_dac_start", int'(seen), 0);
        chk("late_done_ch1", int'(dac_ch1), 0);
        chk("late_done_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
